// File: rtl/gsim_io_ctrl_if.sv
// Handshake and data bundle between the host-side loader/unloader and gsim_io_ctrl.
// The slave side is the controller. The master side is the environment that feeds words and models the solver.
interface gsim_io_ctrl_if;
  logic          i_in_valid;
  logic [15:0]   i_in_data;
  logic          o_in_ready;
  logic [4095:0] o_a;
  logic [255:0]  o_b;
  logic          o_module_en;
  logic          i_done;
  logic [511:0]  i_x;
  logic          o_out_valid;
  logic [31:0]   o_out_data;
  logic          i_out_ready;

  modport slave (
    input  i_in_valid, i_in_data, i_done, i_x, i_out_ready,
    output o_in_ready, o_a, o_b, o_module_en, o_out_valid, o_out_data
  );

  modport master (
    output i_in_valid, i_in_data, i_done, i_x, i_out_ready,
    input  o_in_ready, o_a, o_b, o_module_en, o_out_valid, o_out_data
  );
endinterface

// File: rtl/gsim_io_ctrl.sv
// Solver I/O controller: streams A and b in, runs the solver until a fresh done edge,
// then unloads the 16 x 32-bit result one word per handshake.
module gsim_io_ctrl #(
  parameter int NWORD = 272
) (
  input  logic           i_clk,
  input  logic           i_reset,
  gsim_io_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {S_LOAD, S_RUN, S_OUT} state_t;

  localparam logic [8:0] LAST = 9'(NWORD - 1);

  state_t             state, state_nxt;
  logic [8:0]         cnt;
  logic [3:0]         idx;
  logic               done_q;
  logic [15:0][31:0]  buffer;
  logic               accept, fire, complete;

  assign bus.o_in_ready = (state == S_LOAD) && !i_reset;
  assign accept   = bus.i_in_valid && bus.o_in_ready;
  assign fire     = (state == S_OUT) && bus.o_out_valid && bus.i_out_ready;
  // Only a rising done counts; a level left over from the previous job is ignored.
  assign complete = (state == S_RUN) && bus.i_done && !done_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_LOAD;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:  if (accept && cnt == LAST)   state_nxt = S_RUN;
      S_RUN:   if (complete)                state_nxt = S_OUT;
      S_OUT:   if (fire && idx == 4'd15)    state_nxt = S_LOAD;
      default:                              state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt             <= '0;
      idx             <= '0;
      done_q          <= 1'b1;
      buffer          <= '0;
      bus.o_a         <= '0;
      bus.o_b         <= '0;
      bus.o_module_en <= 1'b0;
      bus.o_out_valid <= 1'b0;
      bus.o_out_data  <= '0;
    end else begin
      // Held at 1 outside S_RUN so the first run cycle sees done_q=1.
      done_q          <= (state == S_RUN) ? bus.i_done : 1'b1;
      bus.o_module_en <= (state_nxt == S_RUN);
      bus.o_out_valid <= (state_nxt == S_OUT);

      if (accept) begin
        cnt <= (cnt == LAST) ? 9'd0 : cnt + 9'd1;
        if (cnt < 9'd256) bus.o_a[{cnt[7:0], 4'b0000} +: 16] <= bus.i_in_data;
        else              bus.o_b[{cnt[3:0], 4'b0000} +: 16] <= bus.i_in_data;
      end

      if (complete) begin
        buffer         <= bus.i_x;
        bus.o_out_data <= bus.i_x[31:0];
      end

      if (fire) begin
        idx            <= idx + 4'd1;
        bus.o_out_data <= buffer[idx + 4'd1];
      end
    end
  end
endmodule

// File: tb/tb_gsim_io_ctrl.sv
// Randomized scoreboard bench for gsim_io_ctrl: driver pushes expected result words,
// a negedge monitor pops and compares on every output handshake.
module tb_gsim_io_ctrl;
  localparam int NW = 272;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gsim_io_ctrl_if bus();
  gsim_io_ctrl #(.NWORD(NW)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

  int          vecs = 0;
  int          errs = 0;
  logic [31:0] sbq[$];
  logic [15:0] words[NW];
  logic        hold_v = 1'b0;
  logic [31:0] hold_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake at the next posedge is visible here at negedge.
  always @(negedge clk) begin
    if (bus.o_out_valid) begin
      if (hold_v) chk("out_stable", bus.o_out_data, hold_d);
      if (bus.i_out_ready) begin
        if (sbq.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
        else chk("out_data", bus.o_out_data, sbq.pop_front());
        hold_v = 1'b0;
      end else begin
        hold_v = 1'b1;
        hold_d = bus.o_out_data;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    bus.i_in_valid  = 1'b0;
    bus.i_out_ready = 1'b0;
    bus.i_done      = 1'b0;
    tick();
    tick();
    chk("rst_in_ready",  32'(bus.o_in_ready),  32'd0);
    chk("rst_module_en", 32'(bus.o_module_en), 32'd0);
    chk("rst_out_valid", 32'(bus.o_out_valid), 32'd0);
    chk("rst_out_data",  bus.o_out_data,       32'd0);
    chk("rst_a_zero",    32'(|bus.o_a),        32'd0);
    chk("rst_b_zero",    32'(|bus.o_b),        32'd0);
    rst = 1'b0;
    sbq.delete();
    #1;
    chk("rel_in_ready", 32'(bus.o_in_ready), 32'd1);
  endtask

  // gap: 0 = valid held high, 1 = toggle every other cycle, 2 = random gaps
  task automatic load_job(input bit ident, input int gap, input int abort_at,
                          input bit done_hi, output bit aborted);
    int k = 0;
    int cyc = 0;
    bit acc;
    aborted = 1'b0;
    for (int i = 0; i < NW; i++)
      if (ident) words[i] = (i < 256) ? (((i / 16) == (i % 16)) ? 16'h0100 : 16'h0000) : 16'(i - 256);
      else       words[i] = 16'($urandom);
    while (k < NW) begin
      if (k == abort_at) begin
        apply_reset();
        aborted = 1'b1;
        return;
      end
      if (cyc > 4000) begin
        chk("load_timeout", 32'(k), 32'(NW));
        return;
      end
      bus.i_in_valid  = (gap == 0) ? 1'b1 : (gap == 1) ? ((cyc % 2) == 0) : 1'($urandom);
      bus.i_in_data   = bus.i_in_valid ? words[k] : 16'($urandom);
      bus.i_done      = done_hi ? 1'b1 : 1'($urandom);
      bus.i_out_ready = 1'($urandom);
      if (k == NW - 1 && bus.i_in_valid) chk("en_before_last", 32'(bus.o_module_en), 32'd0);
      acc = bus.i_in_valid && bus.o_in_ready;
      tick();
      cyc++;
      if (acc) k++;
    end
    bus.i_in_valid = 1'b0;
    chk("en_rise",      32'(bus.o_module_en), 32'd1);
    chk("in_ready_run", 32'(bus.o_in_ready),  32'd0);
    for (int i = 0; i < NW; i++)
      if (i < 256) chk("pack_a", 32'(bus.o_a[i*16 +: 16]), 32'(words[i]));
      else         chk("pack_b", 32'(bus.o_b[(i-256)*16 +: 16]), 32'(words[i]));
    chk("a_word0", 32'(bus.o_a[15:0]),    32'(words[0]));
    chk("b_last",  32'(bus.o_b[255:240]), 32'(words[NW-1]));
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] x;
    for (int i = 0; i < 16; i++) x[i*32 +: 32] = $urandom;
    return x;
  endfunction

  task automatic run_phase(input bit stale, input int delay);
    logic [511:0] x;
    x = rand512();
    if (stale) begin
      // Done still high from the previous job: must not be taken as completion.
      bus.i_done = 1'b1;
      bus.i_x    = rand512();
      repeat (4) begin
        tick();
        chk("en_stale", 32'(bus.o_module_en), 32'd1);
      end
      bus.i_done = 1'b0;
      bus.i_x    = rand512();
      repeat (3) tick();
      chk("en_before_raise", 32'(bus.o_module_en), 32'd1);
      chk("no_out_early",    32'(bus.o_out_valid), 32'd0);
    end else begin
      bus.i_done = 1'b0;
      repeat (delay) begin
        bus.i_x = rand512();
        tick();
      end
      chk("en_held", 32'(bus.o_module_en), 32'd1);
    end
    bus.i_x    = x;
    bus.i_done = 1'b1;
    for (int i = 0; i < 16; i++) sbq.push_back(x[i*32 +: 32]);
    tick();
    bus.i_done = 1'b0;
    bus.i_x    = rand512();
    chk("en_fall",   32'(bus.o_module_en), 32'd0);
    chk("out_valid", 32'(bus.o_out_valid), 32'd1);
  endtask

  task automatic out_phase(input int stall_idx, input int abort_idx);
    int hs = 0;
    int stall = 0;
    int budget = 0;
    while (hs < 16) begin
      if (hs == abort_idx) begin
        apply_reset();
        return;
      end
      if (budget > 400) begin
        chk("out_timeout", 32'(hs), 32'd16);
        return;
      end
      if (hs == stall_idx && stall < 5) begin
        bus.i_out_ready = 1'b0;
        stall++;
      end else begin
        bus.i_out_ready = ($urandom % 4) != 0;
      end
      bus.i_done = 1'($urandom);
      if (bus.o_out_valid && bus.i_out_ready) hs++;
      tick();
      budget++;
    end
    bus.i_out_ready = 1'b0;
    bus.i_done      = 1'b0;
    chk("in_ready_after", 32'(bus.o_in_ready),  32'd1);
    chk("valid_after",    32'(bus.o_out_valid), 32'd0);
    chk("sb_empty",       32'(sbq.size()),      32'd0);
    chk("a_retained", 32'(bus.o_a[17*16 +: 16]), 32'(words[17]));
    chk("b_retained", 32'(bus.o_b[15:0]),        32'(words[256]));
  endtask

  initial begin
    bit ab;
    bus.i_in_data = '0;
    bus.i_x       = '0;
    apply_reset();

    // Identity matrix job with a 20-cycle solver.
    load_job(1'b1, 0, -1, 1'b0, ab);
    run_phase(1'b0, 20);
    out_phase(-1, -1);

    // Gapped load, stale done at run entry, backpressure on idx 3.
    load_job(1'b0, 1, -1, 1'b1, ab);
    run_phase(1'b1, 0);
    out_phase(3, -1);

    // Reset at word 100, then a clean job.
    load_job(1'b0, 0, 100, 1'b0, ab);
    chk("abort_load", 32'(ab), 32'd1);
    load_job(1'b0, 2, -1, 1'b0, ab);
    run_phase(1'b0, int'($urandom_range(1, 30)));
    out_phase(-1, 7);
    chk("abort_out_empty", 32'(sbq.size()), 32'd0);

    // Recovery jobs after the mid-output reset.
    for (int j = 0; j < 3; j++) begin
      load_job(1'b0, j, -1, 1'b0, ab);
      run_phase(1'b0, int'($urandom_range(1, 30)));
      out_phase(int'($urandom_range(0, 15)), -1);
    end

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/gsim_io_ctrl.md
GSIM_IO_CTRL -- requirements
Module: gsim_io_ctrl

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port i_reset, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port i_in_valid, input, 1, upstream word valid.
REQ-004 SHALL have port i_in_data, input, 16, upstream word: matrix A element or vector b element.
REQ-005 SHALL have port o_in_ready, output, 1, block accepts an upstream word this cycle.
REQ-006 SHALL have port o_a, output, 4096, packed matrix A driven to the solver.
REQ-007 SHALL have port o_b, output, 256, packed vector b driven to the solver.
REQ-008 SHALL have port o_module_en, output, 1, solver enable.
REQ-009 SHALL have port i_done, input, 1, solver done flag.
REQ-010 SHALL have port i_x, input, 512, solver result: 16 x 32-bit.
REQ-011 SHALL have port o_out_valid, output, 1, result word valid.
REQ-012 SHALL have port o_out_data, output, 32, result word.
REQ-013 SHALL have port i_out_ready, input, 1, downstream accepts a result word.
REQ-014 SHALL have parameter NWORD, default 272, meaning words per load (256 A + 16 b).

Function
REQ-015 SHALL implement states S_LOAD, S_RUN and S_OUT; reset state SHALL be S_LOAD.
REQ-016 In S_LOAD, o_in_ready SHALL be 1 and i_in_valid SHALL be ignored in all other states.
REQ-017 A word SHALL be accepted on a cycle with i_in_valid=1 and o_in_ready=1; the load counter cnt (9 bit) SHALL then increment.
REQ-018 Word k<256 SHALL be written to o_a[k*16 +: 16] (row-major: row k/16, col k%16); word k>=256 SHALL be written to o_b[(k-256)*16 +: 16].
REQ-019 After word NWORD-1 is accepted, the FSM SHALL enter S_RUN on the next cycle, with cnt cleared to 0.
REQ-020 o_module_en SHALL be a register equal to 1 exactly while the FSM is in S_RUN.
REQ-021 o_a and o_b SHALL hold their values from S_RUN entry through the return to S_LOAD; they change only on accepted words.
REQ-022 In S_RUN the block SHALL register i_done into done_q each cycle; completion is i_done=1 with done_q=0 (rising edge), so a stale done from the previous job is rejected.
REQ-023 On completion the block SHALL capture i_x into a 16 x 32 buffer (element i = i_x[i*32 +: 32]) and enter S_OUT; o_module_en SHALL be 0 from that next cycle.
REQ-024 done_q SHALL be cleared to 1 on S_RUN entry, so that i_done held high on entry is not treated as completion.
REQ-025 In S_OUT, o_out_valid SHALL be 1 and o_out_data SHALL equal buffer[idx] (idx = 4 bit, starting at 0).
REQ-026 o_out_data SHALL be stable while o_out_valid=1 and i_out_ready=0.
REQ-027 On a handshake (o_out_valid=1 and i_out_ready=1), idx SHALL increment; after idx 15 is accepted, idx SHALL wrap to 0 and the FSM SHALL return to S_LOAD on the next cycle.
REQ-028 i_done SHALL be ignored outside S_RUN, and i_out_ready SHALL be ignored outside S_OUT.
REQ-029 There SHALL be no timeout; S_RUN SHALL persist until completion.

Reset
REQ-030 While i_reset=1 at a clock edge, the block SHALL set: state=S_LOAD, cnt=0, idx=0, done_q=1, o_a=0, o_b=0, buffer=0, o_module_en=0, o_out_valid=0 and o_out_data=0.
REQ-031 o_in_ready SHALL be 0 while i_reset=1 and SHALL be 1 on the first cycle after release.
REQ-032 Reset mid-load, mid-run or mid-output SHALL abort the job with no partial result emitted; the next load SHALL restart at word 0.

Verification
REQ-033 Full job: stream 272 words (A = identity * 0x0100, b[i] = i) with valid held high, solver model raising done 20 cycles later -> o_module_en rises the cycle after word 271, then 16 outputs equal to the model's i_x in index order, then o_in_ready=1.
REQ-034 Gapped input: toggle i_in_valid every other cycle -> exactly 272 accepts and identical o_a/o_b packing; o_a[15:0] = word 0, o_b[255:240] = word 271.
REQ-035 Stale done: hold i_done=1 at S_RUN entry, drop it for 3 cycles, then raise it -> capture occurs only on the raise; o_module_en stays 1 until then.
REQ-036 Output backpressure: hold i_out_ready=0 for 5 cycles on idx 3 -> o_out_data constant, no skip or duplicate, 16 total handshakes.
REQ-037 Reset at word 100 of the load and again mid-S_OUT at idx 7 -> all outputs at reset values; the following full job completes correctly from word 0.
